// File: rtl/i2s_dac_serializer_if.sv
// Bundle between the synthesizer and the I2S DAC serializer.
// Carries the sample pair and its handshake in one direction, and the codec pins and status flags in the other.
// Modports: master = synthesizer/driver side, slave = serializer side.
interface i2s_dac_serializer_if #(
  parameter int AUD_BIT_DEPTH = 24
);
  logic [AUD_BIT_DEPTH-1:0] lsound_in;
  logic [AUD_BIT_DEPTH-1:0] rsound_in;
  logic                     data_ready;
  logic                     mute;
  logic                     AUD_BCLK;
  logic                     AUD_DACLRCK;
  logic                     AUD_DACDAT;
  logic                     sample_latched;
  logic                     underrun;

  modport master (
    output lsound_in, rsound_in, data_ready, mute,
    input  AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_latched, underrun
  );

  modport slave (
    input  lsound_in, rsound_in, data_ready, mute,
    output AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_latched, underrun
  );
endinterface

// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: generates BCLK/LRCK from AUDIO_CLK, captures one stereo pair per frame and shifts it out MSB first.
// Latency: capture at the frame edge, MSB on AUD_DACDAT one BCLK period (MCLK_PER_BCLK cycles) later.
// No backpressure: the frame runs freely; a missing data_ready at a frame edge sets the sticky underrun flag.
// Ports: AUDIO_CLK (clock), reset_n (sync, active-low), bus (slave modport: samples, data_ready, mute in;
//        AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_latched, underrun out).
module i2s_dac_serializer #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int MCLK_PER_BCLK = 4,
  parameter int SLOT_BITS     = 32
) (
  input  logic                  AUDIO_CLK,
  input  logic                  reset_n,
  i2s_dac_serializer_if.slave   bus
);

  localparam int DIV_W = (MCLK_PER_BCLK > 2) ? $clog2(MCLK_PER_BCLK) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MCLK_PER_BCLK - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(MCLK_PER_BCLK / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_N    = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DEPTH_N   = BIT_W'(AUD_BIT_DEPTH);

  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                     bclk_q, bclk_d;
  logic                     lrck_q, lrck_d;
  logic                     dat_q, dat_d;
  logic [AUD_BIT_DEPTH-1:0] shadow_l_q, shadow_l_d;
  logic [AUD_BIT_DEPTH-1:0] shadow_r_q, shadow_r_d;
  logic                     pending_q, pending_d;
  logic                     seen_edge_q, seen_edge_d;
  logic                     latched_q, latched_d;
  logic                     underrun_q, underrun_d;

  logic                     div_wrap;
  logic                     frame_edge;
  logic [BIT_W-1:0]         slot_k;
  logic [AUD_BIT_DEPTH-1:0] tx_word;

  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    frame_edge = div_wrap && (bit_cnt_q == BIT_LAST);

    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);

    bit_cnt_d = bit_cnt_q;
    if (div_wrap) begin
      bit_cnt_d = frame_edge ? '0 : bit_cnt_q + BIT_W'(1);
    end

    // Clock outputs are registered images of the next counter values, so
    // LRCK and data only ever move together with a BCLK falling edge.
    bclk_d = (div_cnt_d >= DIV_HALF);
    lrck_d = (bit_cnt_d >= SLOT_N);

    // Shadows only load at the frame edge; k = 0 at that point, so the line
    // is 0 while the new pair settles and the MSB follows one BCLK later.
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    if (frame_edge) begin
      shadow_l_d = bus.mute ? '0 : bus.lsound_in;
      shadow_r_d = bus.mute ? '0 : bus.rsound_in;
    end

    slot_k  = lrck_d ? (bit_cnt_d - SLOT_N) : bit_cnt_d;
    tx_word = '0;
    dat_d   = 1'b0;
    if ((slot_k != '0) && (slot_k <= DEPTH_N)) begin
      // Shift the selected word so bit [DEPTH-k] lands in the MSB position.
      tx_word = (lrck_d ? shadow_r_q : shadow_l_q) << (slot_k - BIT_W'(1));
      dat_d   = tx_word[AUD_BIT_DEPTH-1];
    end

    // A data_ready in the edge cycle itself satisfies that edge only.
    pending_d   = frame_edge ? 1'b0 : (pending_q | bus.data_ready);
    seen_edge_d = seen_edge_q | frame_edge;
    underrun_d  = underrun_q |
                  (frame_edge & seen_edge_q & ~pending_q & ~bus.data_ready);
    latched_d   = frame_edge;
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      dat_q       <= 1'b0;
      shadow_l_q  <= '0;
      shadow_r_q  <= '0;
      pending_q   <= 1'b0;
      seen_edge_q <= 1'b0;
      latched_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      dat_q       <= dat_d;
      shadow_l_q  <= shadow_l_d;
      shadow_r_q  <= shadow_r_d;
      pending_q   <= pending_d;
      seen_edge_q <= seen_edge_d;
      latched_q   <= latched_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.AUD_BCLK       = bclk_q;
  assign bus.AUD_DACLRCK    = lrck_q;
  assign bus.AUD_DACDAT     = dat_q;
  assign bus.sample_latched = latched_q;
  assign bus.underrun       = underrun_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: frame-position model of the I2S stream plus literal expectations.
// Every cycle the five outputs are compared with values derived from the position in the frame.
// Inputs are randomized outside the frame edge to show they are ignored there.
module tb_i2s_dac_serializer;
  localparam int D     = 24;
  localparam int M     = 4;
  localparam int S     = 32;
  localparam int FRAME = 2 * S * M;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2s_dac_serializer_if #(.AUD_BIT_DEPTH(D)) bus ();

  i2s_dac_serializer #(
    .AUD_BIT_DEPTH(D),
    .MCLK_PER_BCLK(M),
    .SLOT_BITS(S)
  ) dut (
    .AUDIO_CLK(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: position inside the frame of the state now shown by the DUT.
  int           mpos = 0;
  logic [D-1:0] cur_l = '0, cur_r = '0;
  bit           pend = 0, seen = 0, und_exp = 0, lat_exp = 0;

  // Bits collected from the line at BCLK rises, per frame.
  logic [D-1:0] col_l = '0, col_r = '0, last_l = '0, last_r = '0;
  bit           pad_seen = 0, last_pad = 0;

  int cyc = 0, release_cyc = 0, first_lat = -1, last_lat_cyc = -1, lat_gap = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, pos %0d)", name, act, exp, cyc, mpos);
    end
  endtask

  task automatic tick();
    int  k;
    bit  edge_now;
    bit  e_bclk, e_lrck, e_dat;
    logic [D-1:0] w;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mpos = 0; cur_l = '0; cur_r = '0;
      pend = 0; seen = 0; und_exp = 0; lat_exp = 0;
      col_l = '0; col_r = '0; pad_seen = 0;
      release_cyc = cyc; first_lat = -1; last_lat_cyc = -1; lat_gap = -1;
    end else begin
      edge_now = (mpos == FRAME - 1);
      if (edge_now) begin
        if (seen && !pend && !bus.data_ready) und_exp = 1;
        cur_l = bus.mute ? '0 : bus.lsound_in;
        cur_r = bus.mute ? '0 : bus.rsound_in;
        seen = 1; pend = 0; lat_exp = 1;
        last_l = col_l; last_r = col_r; last_pad = pad_seen;
        col_l = '0; col_r = '0; pad_seen = 0;
      end else begin
        pend = pend | bus.data_ready;
        lat_exp = 0;
      end
      mpos = (mpos + 1) % FRAME;
    end
    #1;
    // Expected line state from the frame position alone.
    e_bclk = (mpos % M) >= (M / 2);
    e_lrck = (mpos / M) >= S;
    k      = (mpos / M) % S;
    w      = e_lrck ? cur_r : cur_l;
    e_dat  = (k >= 1 && k <= D) ? w[D-k] : 1'b0;
    check("bclk", bus.AUD_BCLK, e_bclk);
    check("lrck", bus.AUD_DACLRCK, e_lrck);
    check("dat", bus.AUD_DACDAT, e_dat);
    check("sample_latched", bus.sample_latched, lat_exp);
    check("underrun", bus.underrun, und_exp);
    if (rst_n && (mpos % M) == (M / 2)) begin
      if (k >= 1 && k <= D) begin
        if (e_lrck) col_r[D-k] = bus.AUD_DACDAT;
        else        col_l[D-k] = bus.AUD_DACDAT;
      end else begin
        pad_seen = pad_seen | bus.AUD_DACDAT;
      end
    end
    if (bus.sample_latched === 1'b1) begin
      if (last_lat_cyc >= 0) lat_gap = cyc - last_lat_cyc;
      if (first_lat < 0) first_lat = cyc - release_cyc;
      last_lat_cyc = cyc;
    end
  endtask

  // Run until the next frame edge has been taken. Data and mute are random
  // except in the edge cycle; data_ready pulses once at position rdy_at.
  task automatic run_frame(input logic [D-1:0] l, input logic [D-1:0] r,
                           input int rdy_at, input bit mute_v);
    bit edge_now;
    for (int n = 0; n < FRAME + 2; n++) begin
      edge_now = (mpos == FRAME - 1);
      bus.lsound_in  = edge_now ? l : D'($urandom);
      bus.rsound_in  = edge_now ? r : D'($urandom);
      bus.mute       = edge_now ? mute_v : 1'($urandom_range(0, 1));
      bus.data_ready = (mpos == rdy_at);
      tick();
      if (edge_now) break;
    end
  endtask

  initial begin
    logic [D-1:0] l0, r0;
    rst_n = 1'b0;
    bus.lsound_in = 24'h123456; bus.rsound_in = 24'h654321;
    bus.data_ready = 1'b1; bus.mute = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("reset_bclk", bus.AUD_BCLK, 0);
    check("reset_lrck", bus.AUD_DACLRCK, 0);
    check("reset_dat", bus.AUD_DACDAT, 0);
    check("reset_latched", bus.sample_latched, 0);
    check("reset_underrun", bus.underrun, 0);
    rst_n = 1'b1;

    // Frame 0 transmits zeros; first capture 256 cycles after release.
    run_frame(24'hA5A5A5, 24'h5A5A5A, 100, 0);
    check("first_frame_left_zero", last_l, 0);
    check("first_frame_right_zero", last_r, 0);
    check("first_capture_delay", first_lat, 256);
    check("no_underrun_first_edge", bus.underrun, 0);

    run_frame(24'hA5A5A5, 24'h5A5A5A, 100, 0);
    check("pattern_left", last_l, 24'hA5A5A5);
    check("pattern_right", last_r, 24'h5A5A5A);
    check("pattern_pad_zero", last_pad, 0);
    check("latched_period", lat_gap, 256);

    // Extremes captured with data_ready coincident with the edge.
    run_frame(24'h800000, 24'h7FFFFF, FRAME - 1, 0);
    check("coincident_no_underrun", bus.underrun, 0);
    run_frame(24'h000011, 24'h000022, 50, 1);
    check("extreme_left", last_l, 24'h800000);
    check("extreme_right", last_r, 24'h7FFFFF);

    // Muted capture gives a silent frame; unmuted data returns after it.
    run_frame(24'h123456, 24'h654321, 50, 0);
    check("mute_left_zero", last_l, 0);
    check("mute_right_zero", last_r, 0);
    check("mute_no_underrun", bus.underrun, 0);

    // Frame without data_ready: underrun at its edge, sticky afterwards.
    run_frame(24'hABCDEF, 24'hFEDCBA, -1, 0);
    check("unmute_left", last_l, 24'h123456);
    check("unmute_right", last_r, 24'h654321);
    check("underrun_set", bus.underrun, 1);
    run_frame(24'h111111, 24'h222222, 10, 0);
    check("underrun_sticky", bus.underrun, 1);

    // Mid-frame reset at bit_cnt 40 (BCLK high at that point).
    bus.data_ready = 1'b0;
    for (int n = 0; n < FRAME && mpos != 162; n++) tick();
    check("pre_reset_bclk_high", bus.AUD_BCLK, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_underrun", bus.underrun, 0);
    check("midreset_lrck", bus.AUD_DACLRCK, 0);
    check("midreset_bclk", bus.AUD_BCLK, 0);
    check("midreset_dat", bus.AUD_DACDAT, 0);
    run_frame(24'h0F0F0F, 24'hF0F0F0, 30, 0);
    check("post_reset_left_zero", last_l, 0);
    check("post_reset_right_zero", last_r, 0);
    check("post_reset_capture_delay", first_lat, 256);
    check("post_reset_no_underrun", bus.underrun, 0);

    // Randomized frames; the per-cycle model does the checking.
    for (int f = 0; f < 20; f++) begin
      l0 = D'($urandom);
      r0 = D'($urandom);
      run_frame(l0, r0,
                ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, FRAME - 1)),
                ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
